// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_pkg
// Brief    : Shared types and constants for the byte-stream program loader.
// Revision : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        RUN    = 3'd5,
        ERR    = 3'd6
    } loader_state_t;

    localparam logic [7:0] MAGIC = 8'hA5;

    localparam int LED_BUSY      = 0;
    localparam int LED_DONE      = 1;
    localparam int LED_ERROR     = 2;
    localparam int LED_HEARTBEAT = 3;

    // States between the magic byte and the checksum byte.
    function automatic logic in_frame(loader_state_t s);
        return s inside {LEN_LO, LEN_HI, DATA, CSUM};
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_if
// Brief    : Byte-source, RAM-write and status bundle of the program loader.
// Revision : 1.0 - initial release
// ============================================================================
interface prog_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  cpu_reset;
    logic [3:0]            led;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_reset, led
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata, cpu_reset, led
    );
endinterface
`default_nettype wire

// File: rtl/prog_loader_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : word_packer
// Brief    : Assembles little-endian bytes into a word and flags the last byte.
// Revision : 1.0 - initial release
// ============================================================================
module word_packer #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_clear,
    input  wire logic                  i_valid,
    input  wire logic [7:0]            i_byte,
    output logic                       o_last,
    output logic [DATA_WIDTH-1:0]      o_word
);
    localparam int c_BPW = DATA_WIDTH / 8;
    localparam int c_CW  = (c_BPW > 1) ? $clog2(c_BPW) : 1;

    logic [c_CW-1:0]       r_cnt;
    logic [DATA_WIDTH-1:0] r_word;

    assign o_last = (r_cnt == c_CW'(c_BPW - 1));

    // Bytes enter at the top and shift down, so the first byte ends at bit 0.
    generate
        if (c_BPW > 1) begin : g_shift
            assign o_word = {i_byte, r_word[DATA_WIDTH-1:8]};
        end else begin : g_single
            assign o_word = i_byte;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_valid) begin
            r_word <= o_word;
            r_cnt  <= o_last ? '0 : r_cnt + c_CW'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Brief    : Framed, checksummed byte-stream RAM loader holding the CPU in reset.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 14,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  wire logic     clk,
    input  wire logic     reset,
    prog_loader_if.slave  bus
);
    localparam logic [31:0] c_MAX_WORDS = 32'((1 << ADDR_WIDTH) - BASE_ADDR);

    loader_state_t         r_state;
    loader_state_t         w_state_next;
    logic [15:0]           r_len;
    logic [16:0]           r_idx;
    logic [7:0]            r_csum;
    logic [31:0]           r_idle;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_cpu_reset;
    logic [3:0]            r_led;

    logic                  w_accept;
    logic                  w_frame_start;
    logic                  w_timeout;
    logic [15:0]           w_len;
    logic [7:0]            w_csum_next;
    logic                  w_pack_valid;
    logic                  w_pack_last;
    logic [DATA_WIDTH-1:0] w_pack_word;

    assign w_accept      = bus.rx_valid;
    assign w_len         = {bus.rx_data, r_len[7:0]};
    assign w_csum_next   = r_csum + bus.rx_data;
    assign w_frame_start = w_accept && (bus.rx_data == MAGIC)
                           && ((r_state == IDLE) || (r_state == ERR));
    assign w_pack_valid  = w_accept && (r_state == DATA);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            assign w_timeout = in_frame(r_state) && !w_accept
                               && (r_idle == 32'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    word_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk     (clk),
        .rst     (reset),
        .i_clear (w_frame_start),
        .i_valid (w_pack_valid),
        .i_byte  (bus.rx_data),
        .o_last  (w_pack_last),
        .o_word  (w_pack_word)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, ERR: if (w_frame_start) w_state_next = LEN_LO;
            LEN_LO:    if (w_accept) w_state_next = LEN_HI;
            LEN_HI: begin
                if (w_accept) begin
                    if (32'(w_len) > c_MAX_WORDS) w_state_next = ERR;
                    else if (w_len == 16'd0)      w_state_next = CSUM;
                    else                          w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_accept && w_pack_last && (r_idx + 17'd1 == {1'b0, r_len}))
                    w_state_next = CSUM;
            end
            CSUM:    if (w_accept) w_state_next = (w_csum_next == 8'h00) ? RUN : ERR;
            RUN:     w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
        if (w_timeout) w_state_next = ERR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_idx       <= '0;
            r_csum      <= '0;
            r_idle      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_reset <= 1'b1;
            r_led       <= 4'b0000;
        end else begin
            r_state  <= w_state_next;
            r_mem_we <= 1'b0;

            if (w_frame_start) begin
                r_idx  <= '0;
                r_csum <= '0;
            end else if (in_frame(r_state) && w_accept) begin
                r_csum <= w_csum_next;
            end

            if (w_accept && (r_state == LEN_LO)) r_len <= {8'h00, bus.rx_data};
            if (w_accept && (r_state == LEN_HI)) r_len <= w_len;

            if (w_pack_valid && w_pack_last) begin
                r_mem_we               <= 1'b1;
                r_mem_addr             <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(r_idx);
                r_mem_wdata            <= w_pack_word;
                r_idx                  <= r_idx + 17'd1;
                r_led[LED_HEARTBEAT]   <= ~r_led[LED_HEARTBEAT];
            end

            if (!in_frame(r_state) || w_accept) r_idle <= '0;
            else                                r_idle <= r_idle + 32'd1;

            // Status flags follow the state being entered so they line up with it.
            r_cpu_reset      <= (w_state_next != RUN);
            r_led[LED_BUSY]  <= in_frame(w_state_next);
            r_led[LED_DONE]  <= (w_state_next == RUN);
            r_led[LED_ERROR] <= (w_state_next == ERR);
        end
    end

    assign bus.rx_ready  = 1'b1;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_reset = r_cpu_reset;
    assign bus.led       = r_led;
endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Brief    : Self-checking bench for prog_loader with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_prog_loader;
    localparam int c_TOUT = 16;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;

    always #5 clk = ~clk;

    prog_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(14)) bus_a ();
    prog_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4))  bus_b ();

    assign bus_a.rx_data  = rx_data;
    assign bus_a.rx_valid = rx_valid;
    assign bus_b.rx_data  = rx_data;
    assign bus_b.rx_valid = rx_valid;

    prog_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(14), .BASE_ADDR(0), .TIMEOUT_CYCLES(c_TOUT))
        u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    prog_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BASE_ADDR(8), .TIMEOUT_CYCLES(c_TOUT))
        u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    // Outputs of both instances widened to common types.
    logic        o_we    [2];
    logic [13:0] o_addr  [2];
    logic [31:0] o_wdata [2];
    logic        o_cpu   [2];
    logic [3:0]  o_led   [2];
    logic        o_ready [2];
    always_comb begin
        o_we[0] = bus_a.mem_we;     o_we[1] = bus_b.mem_we;
        o_addr[0] = bus_a.mem_addr; o_addr[1] = {10'd0, bus_b.mem_addr};
        o_wdata[0] = bus_a.mem_wdata; o_wdata[1] = bus_b.mem_wdata;
        o_cpu[0] = bus_a.cpu_reset; o_cpu[1] = bus_b.cpu_reset;
        o_led[0] = bus_a.led;       o_led[1] = bus_b.led;
        o_ready[0] = bus_a.rx_ready; o_ready[1] = bus_b.rx_ready;
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: mode 0 idle, 1 in frame, 2 run, 3 error.
    localparam int M_IDLE = 0, M_FRAME = 1, M_RUN = 2, M_ERR = 3;
    int          c_base [2] = '{0, 8};
    int          c_maxw [2] = '{16384, 8};
    int          m_mode [2];
    int          m_pos  [2];
    int          m_len  [2];
    int          m_idle [2];
    logic [7:0]  m_sum  [2];
    logic [31:0] m_word [2];
    logic        m_hb   [2];
    logic        e_we   [2];
    logic        e_bus  [2];
    logic [13:0] e_addr [2];
    logic [31:0] e_wdata[2];

    // Log of writes actually seen on each instance.
    int          wr_cnt  [2];
    logic [13:0] wr_addr [2][16];
    logic [31:0] wr_data [2][16];

    task automatic model_step(input int k, input logic rst, input logic v, input logic [7:0] d);
        int i;
        e_we[k]  = 1'b0;
        e_bus[k] = 1'b0;
        if (rst) begin
            m_mode[k] = M_IDLE; m_hb[k] = 1'b0;
            e_bus[k] = 1'b1; e_addr[k] = '0; e_wdata[k] = '0;
            return;
        end
        case (m_mode[k])
            M_IDLE, M_ERR: begin
                if (v && d == 8'hA5) begin
                    m_mode[k] = M_FRAME; m_pos[k] = 0; m_sum[k] = 8'h00; m_idle[k] = 0;
                end
            end
            M_FRAME: begin
                if (v) begin
                    m_idle[k] = 0;
                    m_sum[k]  = m_sum[k] + d;
                    if (m_pos[k] == 0) begin
                        m_len[k] = int'(d);
                    end else if (m_pos[k] == 1) begin
                        m_len[k] = m_len[k] + 256 * int'(d);
                        if (m_len[k] > c_maxw[k]) m_mode[k] = M_ERR;
                    end else if (m_pos[k] < 2 + 4 * m_len[k]) begin
                        i = m_pos[k] - 2;
                        m_word[k] = (i % 4 == 0) ? {24'd0, d}
                                                 : (m_word[k] | (32'(d) << (8 * (i % 4))));
                        if (i % 4 == 3) begin
                            e_we[k] = 1'b1; e_bus[k] = 1'b1;
                            e_addr[k] = 14'(c_base[k] + i / 4);
                            e_wdata[k] = m_word[k];
                            m_hb[k] = ~m_hb[k];
                        end
                    end else begin
                        m_mode[k] = (m_sum[k] == 8'h00) ? M_RUN : M_ERR;
                    end
                    m_pos[k]++;
                end else begin
                    m_idle[k]++;
                    if (m_idle[k] == c_TOUT) m_mode[k] = M_ERR;
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [3:0] exp_led(input int k);
        return {m_hb[k], m_mode[k] == M_ERR, m_mode[k] == M_RUN, m_mode[k] == M_FRAME};
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            wr_cnt[k] = 0;
            model_step(k, 1'b1, 1'b0, 8'h00);
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                logic ok;
                ok = (o_we[k] === e_we[k]) && (o_cpu[k] === (m_mode[k] != M_RUN))
                     && (o_led[k] === exp_led(k)) && (o_ready[k] === 1'b1)
                     && (!e_bus[k] || (o_addr[k] === e_addr[k] && o_wdata[k] === e_wdata[k]));
                n_cmp++;
                if (!ok) begin
                    n_err++;
                    $display("FAIL cycle_check cyc=%0d inst=%0d: got we=%b addr=%h data=%h cpu_reset=%b led=%b ready=%b; want we=%b addr=%h data=%h cpu_reset=%b led=%b ready=1",
                             cyc, k, o_we[k], o_addr[k], o_wdata[k], o_cpu[k], o_led[k], o_ready[k],
                             e_we[k], e_addr[k], e_wdata[k], m_mode[k] != M_RUN, exp_led(k));
                end
                if (o_we[k] === 1'b1) begin
                    wr_addr[k][wr_cnt[k] % 16] = o_addr[k];
                    wr_data[k][wr_cnt[k] % 16] = o_wdata[k];
                    wr_cnt[k]++;
                end
                model_step(k, reset, rx_valid, rx_data);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    logic [7:0] fq[$];

    task automatic send(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b1; gap(1); reset = 1'b0;
        wr_cnt[0] = 0; wr_cnt[1] = 0;
    endtask

    task automatic send_fq(input int maxgap, input bit longgaps);
        for (int i = 0; i < fq.size(); i++) begin
            send(fq[i]);
            if (longgaps && $urandom_range(0, 19) == 0) gap($urandom_range(8, 20));
            else if (maxgap > 0) gap($urandom_range(0, maxgap));
        end
    endtask

    // Checksum byte that makes the sum of everything after MAGIC zero.
    function automatic logic [7:0] csum_of();
        logic [7:0] s = 8'h00;
        for (int i = 1; i < fq.size(); i++) s = s + fq[i];
        return 8'h00 - s;
    endfunction

    task automatic build_frame(input int n, input bit corrupt);
        logic [7:0] c;
        fq = {};
        fq.push_back(8'hA5);
        fq.push_back(8'(n));
        fq.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) fq.push_back(8'($urandom_range(0, 255)));
        c = csum_of();
        fq.push_back(corrupt ? c + 8'h01 : c);
    endtask

    task automatic load_nominal(input logic [7:0] csum);
        fq = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        fq.push_back(csum);
    endtask

    initial begin
        int i;
        logic [7:0] g;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Nominal load; two's complement of the byte sum 8'h4E is 8'hB2.
        wr_cnt[0] = 0; wr_cnt[1] = 0;
        load_nominal(8'h00);
        void'(fq.pop_back());
        check("csum_pin", 32'(csum_of()), 32'h0000_00B2);
        fq.push_back(csum_of());
        send_fq(0, 1'b0);
        check("nom_cpu_reset", 32'(bus_a.cpu_reset), 32'd0);
        check("nom_led", 32'(bus_a.led), 32'h2);
        check("nom_wr_cnt", 32'(wr_cnt[0]), 32'd2);
        check("nom_w0_addr", 32'(wr_addr[0][0]), 32'd0);
        check("nom_w0_data", wr_data[0][0], 32'h1234_5678);
        check("nom_w1_addr", 32'(wr_addr[0][1]), 32'd1);
        check("nom_w1_data", wr_data[0][1], 32'hDEAD_BEEF);
        check("nom_b_w1_addr", 32'(wr_addr[1][1]), 32'd9);

        // Bad checksum, then a good frame from the error state.
        do_reset();
        load_nominal(8'h00);
        send_fq(0, 1'b0);
        check("bad_cpu_reset", 32'(bus_a.cpu_reset), 32'd1);
        check("bad_led", 32'(bus_a.led), 32'h4);
        check("bad_wr_cnt", 32'(wr_cnt[0]), 32'd2);
        load_nominal(8'hB2);
        send_fq(2, 1'b0);
        check("recover_cpu_reset", 32'(bus_a.cpu_reset), 32'd0);
        check("recover_led", 32'(bus_a.led), 32'h2);

        // Oversize length on the 16-word, base-8 instance.
        do_reset();
        fq = '{8'hA5, 8'h09, 8'h00};
        send_fq(0, 1'b0);
        check("over_led", 32'(bus_b.led), 32'h4);
        gap(20);
        check("over_wr_cnt", 32'(wr_cnt[1]), 32'd0);

        // Largest length that fits: eight words ending at address 15.
        do_reset();
        build_frame(8, 1'b0);
        send_fq(0, 1'b0);
        check("fit_led", 32'(bus_b.led), 32'h2);
        check("fit_wr_cnt", 32'(wr_cnt[1]), 32'd8);
        check("fit_last_addr", 32'(wr_addr[1][7]), 32'd15);

        // Zero length preceded by garbage.
        do_reset();
        fq = '{8'h00, 8'h13, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_fq(0, 1'b0);
        check("zero_led", 32'(bus_a.led), 32'h2);
        check("zero_cpu_reset", 32'(bus_a.cpu_reset), 32'd0);
        check("zero_wr_cnt", 32'(wr_cnt[0]), 32'd0);

        // Timeout after three data bytes.
        do_reset();
        fq = '{8'h3C, 8'h5A, 8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
        send_fq(0, 1'b0);
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_a.led[2] === 1'b1) break;
        end
        check("timeout_idle_cycles", 32'(i), 32'd16);
        @(posedge clk); #1;

        // Reset in the middle of word 1.
        do_reset();
        fq = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_fq(0, 1'b0);
        reset = 1'b1; rx_data = 8'h07; rx_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; rx_valid = 1'b0;
        check("rst_led", 32'(bus_a.led), 32'h0);
        check("rst_cpu_reset", 32'(bus_a.cpu_reset), 32'd1);
        check("rst_mem_wdata", bus_a.mem_wdata, 32'd0);
        check("rst_mem_addr", 32'(bus_a.mem_addr), 32'd0);
        send(8'h08);
        gap(5);
        check("rst_wr_cnt", 32'(wr_cnt[0]), 32'd1);

        // Randomised frames, gaps, corruption and garbage.
        for (int it = 0; it < 40; it++) begin
            if (m_mode[0] == M_RUN || m_mode[1] == M_RUN || $urandom_range(0, 1) == 1)
                do_reset();
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h00;
                send(g);
            end
            build_frame($urandom_range(0, 10), $urandom_range(0, 3) == 0);
            send_fq(3, 1'b1);
            gap($urandom_range(0, 3));
        end
        gap(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        n_err++;
        $display("FAIL watchdog: got no completion by %0t, want completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
